mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Moore-style sequencing controller for the multicycle MIPS datapath: walks each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select. Sits beside the shared instruction/data memory and stalls on a memory ready handshake. It replaces the single-cycle decoder pair when the core is built in multicycle mode.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  6  opcode from instruction register (stable from DECODE onward)
- funct  input  6  funct field from instruction register
- zero  input  1  ALU zero flag
- memready  input  1  memory completes current access this cycle
- iord  output  1  memory address select (0 = PC, 1 = ALUOut)
- memwrite  output  1  memory write request
- membyteread  output  1  byte-load select for load data path
- irwrite  output  1  instruction register load
- regdst  output  1  write register select (1 = rd)
- memtoreg  output  1  writeback data select (1 = memory data)
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select (0 = PC, 1 = rs)
- alusrcb  output  2  ALU B select (00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- pcsrc  output  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
- pcen  output  1  PC register enable
- alucontrol  output  3  ALU function
- state  output  4  current state encoding, for debug/trace

## Operation
- State encodings (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BRANCHEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 unreachable; if entered, next state is FETCH.
- Opcodes: lw 100011, lb 100000, sw 101011, R-type 000000, beq 000100, bne 000101 (config), addi 001000, j 000010.
- Transitions: FETCH -> DECODE on memready, else hold. DECODE -> MEMADR (lw/lb/sw), RTYPEEX, BRANCHEX, ADDIEX, JEX; any other opcode -> FETCH (treated as nop). MEMADR -> MEMRD (lw/lb) or MEMWR (sw). MEMRD -> MEMWB on memready, else hold. MEMWR -> FETCH on memready, else hold. RTYPEEX -> ALUWB. ADDIEX -> ADDIWB. MEMWB, ALUWB, ADDIWB, BRANCHEX, JEX -> FETCH.
- Outputs are decoded from state; all outputs default 0, with alusrcb defaulting 00 and alucontrol defaulting 010.
  - FETCH: alusrcb 01, alucontrol 010, irwrite = pcen = memready.
  - DECODE: alusrcb 11, alucontrol 010.
  - MEMADR, ADDIEX: alusrca 1, alusrcb 10, alucontrol 010.
  - MEMRD: iord 1.
  - MEMWB: memtoreg 1, regwrite 1.
  - MEMWR: iord 1, memwrite 1.
  - RTYPEEX: alusrca 1, alucontrol from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010.
  - ALUWB: regdst 1, regwrite 1.
  - ADDIWB: regwrite 1.
  - BRANCHEX: alusrca 1, alucontrol 110, pcsrc 01, pcen = zero for beq (and ~zero for bne).
  - JEX: pcsrc 10, pcen 1.
- membyteread = 1 in MEMRD and MEMWB when op = lb.
- Memory handshake: request is implied by state (FETCH, MEMRD, MEMWR). Request is held level until memready. memready outside these states is ignored.

## Timing
- reset asynchronous: state = FETCH immediately. While reset is high, irwrite, pcen, memwrite and regwrite are forced 0; other outputs take FETCH values.
- Reset deasserted mid-instruction: restart at FETCH, with no partial writeback.
- Latency with memready tied high: R-type, addi, sw 4 cycles; lw/lb 5; beq/bne/j 3; unknown opcode 2.
- Each memory wait cycle adds exactly 1 cycle in the waiting state, with outputs held constant.
- pcen in BRANCHEX is combinational on zero in the same cycle.

## Configuration
- MIPS_MC_BNE_EN defined: opcode 000101 routes DECODE -> BRANCHEX and sets pcen = ~zero.
- Not defined: 000101 is an unknown opcode (DECODE -> FETCH), and BRANCHEX behaves as beq only.

## Test plan
- Reset asserted in ALUWB mid add: state = 0 asynchronously, regwrite = 0 → after release, fetch restarts and PC advances by 4 only on memready.
- lw with memready low for 3 cycles in FETCH and 2 cycles in MEMRD: total 10 cycles; regwrite is pulsed once in MEMWB with memtoreg = 1.
- lb: membyteread = 1 in MEMRD and MEMWB, and 0 in all other states.
- beq with zero = 1: pcen = 1 and pcsrc = 01; with zero = 0: pcen = 0. bne is inverted with MIPS_MC_BNE_EN; without it, 000101 goes to FETCH after 2 cycles.
- R-type with funct 101010: alucontrol = 111 in RTYPEEX, then regdst = 1 and regwrite = 1 in ALUWB. Unknown funct gives 010.
- sw with memready low for 4 cycles in MEMWR: memwrite and iord are held at 1 for 5 cycles, then the controller returns to FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | mips_multicycle_ctrl                                                       |
// | Moore sequencing controller for the multicycle MIPS datapath.              |
// | Optional feature macro: MIPS_MC_BNE_EN (adds bne via the branch state).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       membyteread,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPEEX  = 4'd6,
        ALUWB    = 4'd7,
        BRANCHEX = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JEX      = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_branch_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_LB, OP_SW: w_next = MEMADR;
                    OP_RTYPE:            w_next = RTYPEEX;
                    OP_BEQ:              w_next = BRANCHEX;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:              w_next = BRANCHEX;
`endif
                    OP_ADDI:             w_next = ADDIEX;
                    OP_J:                w_next = JEX;
                    default:             w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    w_next = memready ? MEMWB : MEMRD;
            MEMWR:    w_next = memready ? FETCH : MEMWR;
            RTYPEEX:  w_next = ALUWB;
            ADDIEX:   w_next = ADDIWB;
            default:  w_next = FETCH;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    assign w_branch_take = (op == OP_BNE) ? ~zero : zero;
`else
    assign w_branch_take = zero;
`endif

    always_comb begin
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcen        = 1'b0;
        alucontrol  = 3'b010;
        case (r_state)
            FETCH: begin
                alusrcb = 2'b01;
                // Reset holds the state in FETCH; suppress its write strobes.
                irwrite = memready & ~reset;
                pcen    = memready & ~reset;
            end
            DECODE:   alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:    iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB:   regwrite = 1'b1;
            BRANCHEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = w_branch_take;
            end
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign membyteread = ((r_state == MEMRD) || (r_state == MEMWB)) && (op == OP_LB);
    assign state       = r_state;

endmodule

`default_nettype wire
